// File: rtl/cls_fault_handler.sv
// Lockstep fault handler: filters compare-unit glitches, drives a timed core reset
// with a recovery budget, and locks fatally once the budget is spent. Optional macro: CLS_FAULT_LOG_EN.
module cls_fault_handler #(
   parameter int RST_PULSE_CYCLES = 16,
   parameter int MAX_RECOVERIES   = 3,
   parameter int SETTLE_CYCLES    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fault_i,
   input  logic [2:0] fault_vec_i,
   input  logic       clear_i,
   output logic       core_rst_o,
   output logic       recovering_o,
   output logic       fatal_o,
   output logic       irq_o,
   output logic [7:0] fault_cnt_o,
   output logic [2:0] last_fault_vec_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONFIRM,
      ST_RESET,
      ST_SETTLE,
      ST_FATAL
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic [3:0] r_recov;
   logic [3:0] w_recov_nxt;
   logic       r_irq;
   logic       w_irq_nxt;
   logic       w_confirm;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
         r_recov <= 4'd0;
         r_irq   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_recov <= w_recov_nxt;
         r_irq   <= w_irq_nxt;
      end
   end

   // The shared down-counter times both the reset pulse and the settle window.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_recov_nxt = r_recov;
      w_irq_nxt   = 1'b0;
      w_confirm   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (clear_i) begin
               w_recov_nxt = 4'd0;
            end
            if (fault_i) begin
               w_state_nxt = ST_CONFIRM;
            end
         end
         ST_CONFIRM: begin
            if (fault_i) begin
               w_confirm = 1'b1;
               w_irq_nxt = 1'b1;
               if (r_recov == 4'(MAX_RECOVERIES)) begin
                  w_state_nxt = ST_FATAL;
               end else begin
                  w_recov_nxt = r_recov + 4'd1;
                  w_state_nxt = ST_RESET;
                  w_cnt_nxt   = 8'(RST_PULSE_CYCLES - 1);
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RESET: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = ST_SETTLE;
               w_cnt_nxt   = 8'(SETTLE_CYCLES - 1);
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         ST_FATAL: begin
            if (clear_i) begin
               w_state_nxt = ST_IDLE;
               w_recov_nxt = 4'd0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign core_rst_o   = (r_state == ST_RESET) || (r_state == ST_FATAL);
   assign recovering_o = (r_state == ST_RESET) || (r_state == ST_SETTLE);
   assign fatal_o      = (r_state == ST_FATAL);
   assign irq_o        = r_irq;

`ifdef CLS_FAULT_LOG_EN
   logic [2:0] r_hold;
   logic [2:0] r_last_vec;
   logic [7:0] r_fault_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold      <= 3'd0;
         r_last_vec  <= 3'd0;
         r_fault_cnt <= 8'd0;
      end else begin
         if ((r_state == ST_IDLE) && fault_i) begin
            r_hold <= fault_vec_i;
         end
         if (w_confirm) begin
            r_last_vec <= r_hold;
            if (r_fault_cnt != 8'hFF) begin
               r_fault_cnt <= r_fault_cnt + 8'd1;
            end
         end
      end
   end

   assign fault_cnt_o      = r_fault_cnt;
   assign last_fault_vec_o = r_last_vec;
`else
   logic w_unused_log;
   assign w_unused_log     = ^{fault_vec_i, w_confirm};
   assign fault_cnt_o      = 8'd0;
   assign last_fault_vec_o = 3'd0;
`endif

endmodule

// File: tb/tb_cls_fault_handler.sv
// Scoreboard bench for cls_fault_handler: a remaining-cycles reference model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_cls_fault_handler;

   localparam int RPC  = 16;
   localparam int MAXR = 3;
   localparam int SC   = 4;
`ifdef CLS_FAULT_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       fault_i;
   logic [2:0] fault_vec_i;
   logic       clear_i;
   logic       core_rst_o;
   logic       recovering_o;
   logic       fatal_o;
   logic       irq_o;
   logic [7:0] fault_cnt_o;
   logic [2:0] last_fault_vec_o;

   always #5 clk = ~clk;

   cls_fault_handler #(
      .RST_PULSE_CYCLES(RPC),
      .MAX_RECOVERIES  (MAXR),
      .SETTLE_CYCLES   (SC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .fault_i         (fault_i),
      .fault_vec_i     (fault_vec_i),
      .clear_i         (clear_i),
      .core_rst_o      (core_rst_o),
      .recovering_o    (recovering_o),
      .fatal_o         (fatal_o),
      .irq_o           (irq_o),
      .fault_cnt_o     (fault_cnt_o),
      .last_fault_vec_o(last_fault_vec_o)
   );

   typedef struct {
      logic       core_rst;
      logic       recovering;
      logic       fatal;
      logic       irq;
      logic [7:0] cnt;
      logic [2:0] vec;
   } exp_t;

   exp_t q[$];
   exp_t m_exp;
   int   errors = 0;
   int   checks = 0;

   // Reference model: a pending flag plus remaining-cycle counts for each window.
   bit       m_pend, m_fatal, m_irq;
   int       m_pulse_left, m_settle_left, m_used, m_cnt;
   logic [2:0] m_hold, m_last;

   task automatic model_step(input logic r, input logic f, input logic [2:0] v, input logic c);
      m_irq = 1'b0;
      if (r) begin
         m_pend = 0; m_fatal = 0; m_pulse_left = 0; m_settle_left = 0;
         m_used = 0; m_cnt = 0; m_hold = 3'd0; m_last = 3'd0;
      end else if (m_fatal) begin
         if (c) begin
            m_fatal = 0;
            m_used  = 0;
         end
      end else if (m_pulse_left > 0) begin
         m_pulse_left--;
         if (m_pulse_left == 0) m_settle_left = SC;
      end else if (m_settle_left > 0) begin
         m_settle_left--;
      end else if (m_pend) begin
         m_pend = 0;
         if (f) begin
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_last = m_hold;
            m_irq  = 1'b1;
            if (m_used == MAXR) begin
               m_fatal = 1;
            end else begin
               m_used++;
               m_pulse_left = RPC;
            end
         end
      end else begin
         if (c) m_used = 0;
         if (f) begin
            m_pend = 1;
            m_hold = v;
         end
      end
      m_exp.core_rst   = (m_pulse_left > 0) || m_fatal;
      m_exp.recovering = (m_pulse_left > 0) || (m_settle_left > 0);
      m_exp.fatal      = m_fatal;
      m_exp.irq        = m_irq;
      m_exp.cnt        = LOG ? 8'(m_cnt) : 8'd0;
      m_exp.vec        = LOG ? m_last : 3'd0;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic r, input logic f, input logic [2:0] v, input logic c);
      @(negedge clk);
      rst = r; fault_i = f; fault_vec_i = v; clear_i = c;
      model_step(r, f, v, c);
      @(posedge clk);
      q.push_back(m_exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("core_rst_o",       {7'd0, core_rst_o},   {7'd0, e.core_rst});
         chk("recovering_o",     {7'd0, recovering_o}, {7'd0, e.recovering});
         chk("fatal_o",          {7'd0, fatal_o},      {7'd0, e.fatal});
         chk("irq_o",            {7'd0, irq_o},        {7'd0, e.irq});
         chk("fault_cnt_o",      fault_cnt_o,          e.cnt);
         chk("last_fault_vec_o", {5'd0, last_fault_vec_o}, {5'd0, e.vec});
      end
   end

   initial begin
      rst = 1'b1; fault_i = 1'b0; fault_vec_i = 3'd0; clear_i = 1'b0;
      repeat (3) cyc(1, 0, 3'd0, 0);
      // single-cycle glitch
      cyc(0, 1, 3'b001, 0);
      repeat (3) cyc(0, 0, 3'd0, 0);
      // one confirmed fault on slave 1, full pulse and settle
      cyc(0, 1, 3'b010, 0);
      cyc(0, 1, 3'b010, 0);
      repeat (24) cyc(0, 0, 3'd0, 0);
      // clear budget, then fault held high through every settle window until fatal
      cyc(0, 0, 3'd0, 1);
      repeat (96) cyc(0, 1, 3'b100, 0);
      repeat (5) cyc(0, 1, 3'b001, 0);
      // clear from fatal, next confirmation recovers normally
      cyc(0, 0, 3'd0, 1);
      cyc(0, 1, 3'b001, 0);
      cyc(0, 1, 3'b001, 0);
      repeat (24) cyc(0, 0, 3'd0, 0);
      // reset in the fifth cycle of the pulse
      cyc(0, 1, 3'b011, 0);
      cyc(0, 1, 3'b011, 0);
      repeat (4) cyc(0, 0, 3'd0, 0);
      cyc(1, 0, 3'd0, 0);
      repeat (3) cyc(0, 0, 3'd0, 0);
      // simultaneous fault and clear in idle, then counter saturation run
      repeat (300) begin
         cyc(0, 1, 3'($urandom_range(0, 7)), 1);
         cyc(0, 1, 3'd0, 0);
         repeat (20) cyc(0, 0, 3'd0, 0);
         cyc(0, 0, 3'd0, 1);
      end
      // reset while fatal
      repeat (4) begin
         cyc(0, 1, 3'b110, 0);
         cyc(0, 1, 3'b110, 0);
         repeat (20) cyc(0, 0, 3'd0, 0);
      end
      repeat (3) cyc(0, 0, 3'd0, 0);
      cyc(1, 0, 3'd0, 0);
      cyc(0, 0, 3'd0, 0);
      // random traffic
      repeat (3000) begin
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
             3'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 8'(q.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
